// File: rtl/controle_temporizador_rr.sv
// Round-robin scheduler that shares one modulo-M timer among NREQ requesters.
// It grants the timer to one owner at a time, sequences the timer through
// clear/count/terminal-count, and reports half-time and expiry to the owner.
// Every output except timer_conta is decoded from registered state.
module controle_temporizador_rr #(
  parameter int NREQ = 2,
  parameter int W_ID = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            pausa,
  input  logic            fim_timer,
  input  logic            meio_timer,
  output logic            timer_zera,
  output logic            timer_conta,
  output logic [NREQ-1:0] grant,
  output logic [W_ID-1:0] grant_id,
  output logic [NREQ-1:0] meio,
  output logic [NREQ-1:0] done,
  output logic [2:0]      db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PREPARA = 3'd1,
    CONTA   = 3'd2,
    FIM     = 3'd3,
    ABORTA  = 3'd4
  } estado_t;

  estado_t         state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [W_ID-1:0] gid_q, gid_d;
  logic [W_ID-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] meio_q, meio_d;
  logic            meio_sent_q, meio_sent_d;

  logic            found_s;
  logic [W_ID-1:0] sel_s;
  logic            owner_req_s;
  logic            conta_s;

  // Binary index to one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot_f(input logic [W_ID-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (idx == W_ID'(j)) begin
        v[j] = 1'b1;
      end else begin
        v[j] = 1'b0;
      end
    end
    return v;
  endfunction

  // The owner still wants the timer when its request bit is held.
  assign owner_req_s = |(req & grant_q);

  // Round-robin pick: the set request closest after ptr (ptr itself is searched last).
  always_comb begin
    int dist_v;
    int best_v;
    found_s = 1'b0;
    sel_s   = '0;
    best_v  = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      dist_v = j - int'(ptr_q) - 1;
      if (dist_v < 0) begin
        dist_v = dist_v + NREQ;
      end else begin
        dist_v = dist_v;
      end
      if (req[j] && (dist_v < best_v)) begin
        best_v  = dist_v;
        sel_s   = W_ID'(j);
        found_s = 1'b1;
      end else begin
        best_v  = best_v;
      end
    end
  end

  // Next-state, grant bookkeeping and the Mealy count enable.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gid_d       = gid_q;
    ptr_d       = ptr_q;
    meio_d      = '0;
    meio_sent_d = meio_sent_q;
    conta_s     = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (found_s) begin
          grant_d     = onehot_f(sel_s);
          gid_d       = sel_s;
          ptr_d       = sel_s;
          meio_sent_d = 1'b0;
          state_d     = PREPARA;
        end else begin
          state_d     = OCIOSO;
        end
      end
      PREPARA: begin
        state_d = CONTA;
      end
      CONTA: begin
        conta_s = ~pausa;
        if (!owner_req_s) begin
          // Abort wins over expiry and suppresses a pending half-time pulse.
          state_d = ABORTA;
        end else begin
          if (meio_timer && !pausa && !meio_sent_q) begin
            meio_d      = grant_q;
            meio_sent_d = 1'b1;
          end else begin
            meio_d      = '0;
          end
          if (fim_timer && !pausa) begin
            state_d = FIM;
          end else begin
            state_d = CONTA;
          end
        end
      end
      FIM: begin
        grant_d = '0;
        state_d = OCIOSO;
      end
      ABORTA: begin
        grant_d = '0;
        state_d = OCIOSO;
      end
      default: begin
        grant_d = '0;
        state_d = OCIOSO;
      end
    endcase
  end

  // State and grant registers; reset abandons any grant with no done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= OCIOSO;
      grant_q     <= '0;
      gid_q       <= '0;
      ptr_q       <= W_ID'(NREQ - 1);
      meio_q      <= '0;
      meio_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gid_q       <= gid_d;
      ptr_q       <= ptr_d;
      meio_q      <= meio_d;
      meio_sent_q <= meio_sent_d;
    end
  end

  assign timer_zera  = (state_q == PREPARA) || (state_q == ABORTA);
  assign timer_conta = conta_s;
  assign grant       = grant_q;
  assign grant_id    = gid_q;
  assign meio        = meio_q;
  assign done        = (state_q == FIM) ? grant_q : '0;
  assign db_estado   = state_q;

endmodule

// File: tb/tb_controle_temporizador_rr.sv
// Bench for controle_temporizador_rr: a modulo-5 timer, a transaction-level
// model of the scheduler checked every cycle, and directed scenarios with
// hand-computed expectations.
module tb_controle_temporizador_rr;

  localparam int NREQ = 2;
  localparam int W_ID = 3;
  localparam int M    = 5;

  logic            clock;
  logic            reset_n;
  logic [NREQ-1:0] req;
  logic            pausa;
  logic            fim_timer;
  logic            meio_timer;
  logic            timer_zera;
  logic            timer_conta;
  logic [NREQ-1:0] grant;
  logic [W_ID-1:0] grant_id;
  logic [NREQ-1:0] meio;
  logic [NREQ-1:0] done;
  logic [2:0]      db_estado;

  int checks = 0;
  int errors = 0;

  controle_temporizador_rr #(.NREQ(NREQ), .W_ID(W_ID)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .pausa      (pausa),
    .fim_timer  (fim_timer),
    .meio_timer (meio_timer),
    .timer_zera (timer_zera),
    .timer_conta(timer_conta),
    .grant      (grant),
    .grant_id   (grant_id),
    .meio       (meio),
    .done       (done),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared modulo-M timer.
  int tq;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)         tq <= 0;
    else if (timer_zera)  tq <= 0;
    else if (timer_conta) tq <= (tq + 1) % M;
  end
  assign fim_timer  = (tq == M - 1);
  assign meio_timer = (tq == M / 2 - 1);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int m_owner, m_last, m_ptr, m_age, m_ticks;
  bit m_done, m_abort, m_meio, m_meio_sent;
  int m_pick;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int d = 1; d <= NREQ; d++) begin
      if (r[(p + d) % NREQ]) return (p + d) % NREQ;
    end
    return -1;
  endfunction

  always_comb m_pick = rr_pick(req, m_ptr);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1; m_last <= 0; m_ptr <= NREQ - 1; m_age <= 0; m_ticks <= 0;
      m_done <= 0; m_abort <= 0; m_meio <= 0; m_meio_sent <= 0;
    end else begin
      m_meio <= 0;
      if (m_owner < 0) begin
        if (m_pick >= 0) begin
          m_owner <= m_pick; m_last <= m_pick; m_ptr <= m_pick;
          m_age <= 1; m_ticks <= 0; m_meio_sent <= 0;
        end
      end else if (m_done || m_abort) begin
        m_owner <= -1; m_done <= 0; m_abort <= 0;
      end else if (m_age == 1) begin
        m_age <= 2;
      end else if (!req[m_owner]) begin
        m_abort <= 1;
      end else if (!pausa) begin
        if (m_ticks == M / 2 - 1 && !m_meio_sent) begin
          m_meio <= 1; m_meio_sent <= 1;
        end
        if (m_ticks == M - 1) m_done <= 1;
        m_ticks <= (m_ticks + 1) % M;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (reset_n) begin
      int eg, es;
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      if (m_owner < 0)      es = 0;
      else if (m_age == 1)  es = 1;
      else if (m_done)      es = 3;
      else if (m_abort)     es = 4;
      else                  es = 2;
      chk("m_grant", int'(grant), eg);
      chk("m_grant_id", int'(grant_id), m_last);
      chk("m_state", int'(db_estado), es);
      chk("m_zera", int'(timer_zera), int'(m_owner >= 0 && (m_age == 1 || m_abort)));
      chk("m_conta", int'(timer_conta),
          int'(m_owner >= 0 && m_age == 2 && !m_done && !m_abort && !pausa));
      chk("m_done", int'(done), m_done ? eg : 0);
      chk("m_meio", int'(meio), m_meio ? eg : 0);
    end
  end

  int meio_cnt = 0;
  always @(negedge clock) if (reset_n && meio != '0) meio_cnt <= meio_cnt + 1;

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_q(input int val, input string name);
    bit found = 0;
    int n = 0;
    while (!found && n < 30) begin
      step(1);
      n++;
      if (db_estado == 3'd2 && tq == val) found = 1;
    end
    if (!found) chk(name, int'(found), 1);
  endtask

  task automatic wait_done(input string name);
    bit found = 0;
    int n = 0;
    while (!found && n < 30) begin
      step(1);
      n++;
      if (done != '0) found = 1;
    end
    if (!found) chk(name, int'(found), 1);
  endtask

  initial begin
    int base, lat;
    reset_n = 1'b0; req = '0; pausa = 1'b0;
    step(2);
    chk("rst_grant", int'(grant), 0);
    chk("rst_state", int'(db_estado), 0);
    chk("rst_gid", int'(grant_id), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1'b1;
    step(1);

    // Reset in the middle of a count.
    req = 2'b01;
    wait_q(3, "t1_wait_timeout");
    #1 reset_n = 1'b0;
    #1;
    chk("t1_async_grant", int'(grant), 0);
    chk("t1_async_state", int'(db_estado), 0);
    chk("t1_async_done", int'(done), 0);
    req = '0;
    step(1);
    chk("t1_nodone", int'(done), 0);
    step(1);
    chk("t1_nodone2", int'(done), 0);
    reset_n = 1'b1;
    step(1);

    // Contention: ptr starts at NREQ-1, so requester 0 wins first.
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done("t3_done_timeout");
      chk("t3_rr_done", int'(done), (i % 2 == 0) ? 1 : 2);
      if (i == 3) req = '0;
      step(1);
      chk("t3_pulse_len", int'(done), 0);
    end
    step(2);

    // Single request timeline.
    req = 2'b01;
    step(1);
    chk("t2_grant", int'(grant), 1);
    chk("t2_prepara", int'(db_estado), 1);
    chk("t2_zera", int'(timer_zera), 1);
    step(1);
    chk("t2_conta_state", int'(db_estado), 2);
    chk("t2_conta", int'(timer_conta), 1);
    step(2);
    chk("t2_meio", int'(meio), 1);
    step(3);
    chk("t2_done", int'(done), 1);
    chk("t2_fim", int'(db_estado), 3);
    req = '0;
    step(1);
    chk("t2_free", int'(grant), 0);
    chk("t2_idle", int'(db_estado), 0);
    chk("t2_gid_hold", int'(grant_id), 0);
    chk("t2_wrap_q", tq, 0);
    step(1);

    // Pause at half time and at terminal count.
    base = meio_cnt;
    req = 2'b01;
    wait_q(1, "t4_q1_timeout");
    pausa = 1'b1;
    step(2);
    pausa = 1'b0;
    wait_q(4, "t4_q4_timeout");
    pausa = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t4_paused_done", int'(done), 0);
      chk("t4_paused_state", int'(db_estado), 2);
    end
    pausa = 1'b0;
    step(1);
    chk("t4_done", int'(done), 1);
    chk("t4_one_meio", meio_cnt - base, 1);
    req = '0;
    step(2);

    // Abort: owner 0 drops at Q=2, requester 1 takes over.
    req = 2'b01;
    step(1);
    req = 2'b11;
    wait_q(2, "t5_q2_timeout");
    req = 2'b10;
    step(1);
    chk("t5_aborta", int'(db_estado), 4);
    chk("t5_zera", int'(timer_zera), 1);
    chk("t5_nodone", int'(done), 0);
    step(1);
    chk("t5_idle", int'(db_estado), 0);
    chk("t5_free", int'(grant), 0);
    step(1);
    chk("t5_grant1", int'(grant), 2);
    chk("t5_gid1", int'(grant_id), 1);
    wait_done("t5_done_timeout");
    chk("t5_done1", int'(done), 2);
    req = '0;
    step(2);

    // Wrap: full count again, request-to-done latency M+2 edges.
    chk("t6_q0", tq, 0);
    req = 2'b01;
    lat = 0;
    while (done == '0 && lat < 30) begin
      step(1);
      lat++;
    end
    chk("t6_latency", lat, M + 2);
    chk("t6_done", int'(done), 1);
    req = '0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
